// File: rtl/mem_arb_pkg.sv
// Shared types and parameter bounds for the IF/MEM data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF       = 12;
    localparam int DATA_W_DEF       = 16;
    localparam int RD_LAT_MIN       = 1;
    localparam int RD_LAT_MAX       = 4;
    localparam int STARVE_LIMIT_MIN = 1;
    localparam int STARVE_LIMIT_MAX = 15;
    localparam int LAT_CNT_W        = 3;
    localparam int STARVE_CNT_W     = 4;

    // True on the last wait cycle of a read, when memory data is on the bus.
    function automatic logic lat_final(input logic [LAT_CNT_W-1:0] cnt, input int rd_lat);
        return (cnt == LAT_CNT_W'(rd_lat - 1));
    endfunction

endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks the single outstanding read: latency counter plus the owner that will
// receive the data, and flags the cycle on which the memory data is valid.
module mem_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   busy,
    input  logic   start,
    input  owner_e start_owner,
    output logic   final_cyc,
    output owner_e owner
);

    logic [LAT_CNT_W-1:0] cnt_r;
    owner_e               owner_r;
    logic                 final_s;

    assign final_s   = busy & lat_final(cnt_r, RD_LAT);
    assign final_cyc = final_s;
    assign owner     = owner_r;

    // Counter restarts on every read grant, including one issued on a final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {LAT_CNT_W{1'b0}};
            owner_r <= OWN_IF;
        end else if (start) begin
            cnt_r   <= {LAT_CNT_W{1'b0}};
            owner_r <= start_owner;
        end else if (busy && !final_s) begin
            cnt_r   <= cnt_r + LAT_CNT_W'(1);
            owner_r <= owner_r;
        end else begin
            cnt_r   <= cnt_r;
            owner_r <= owner_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between IF fetches and MEM loads/stores.
// Optional IF starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] Memory_addressbus,
    output logic [DATA_W-1:0] Memory_wdata,
    input  logic [DATA_W-1:0] Memory_rdata,
    output logic              Memory_enable,
    output logic              Memory_writemode
);

    localparam logic [0:0] S_IDLE    = IDLE;
    localparam logic [0:0] S_RD_WAIT = RD_WAIT;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT out of range");
    end
    if (STARVE_LIMIT < STARVE_LIMIT_MIN || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range");
    end

    logic [0:0] state_r;
    logic       rst_q_r;
    logic       out_en_s;
    logic       rd_final_s;
    owner_e     rd_owner_s;
    logic       slot_s;
    logic       force_if_s;
    logic       if_win_s;
    logic       mem_win_s;
    logic       rd_grant_s;
    logic       rvalid_s;

    // Nothing is granted or returned while rst is high or in the cycle after.
    assign out_en_s   = ~rst & ~rst_q_r;
    assign slot_s     = out_en_s & ((state_r == S_IDLE) | rd_final_s);
    assign rd_grant_s = if_win_s | (mem_win_s & ~mem_we);
    assign rvalid_s   = out_en_s & rd_final_s;

`ifdef ARB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_r;

    assign force_if_s = (starve_cnt_r == STARVE_CNT_W'(STARVE_LIMIT));

    // Counts slots lost by a waiting IF request; any IF grant or drop clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {STARVE_CNT_W{1'b0}};
        end else if (!if_req || if_win_s) begin
            starve_cnt_r <= {STARVE_CNT_W{1'b0}};
        end else if (mem_win_s && !force_if_s) begin
            starve_cnt_r <= starve_cnt_r + STARVE_CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign force_if_s = 1'b0;
`endif

    // Fixed MEM-over-IF priority, overridden only by the starvation guard.
    always_comb begin
        if_win_s  = 1'b0;
        mem_win_s = 1'b0;
        if (!slot_s) begin
            if_win_s  = 1'b0;
            mem_win_s = 1'b0;
        end else if (force_if_s && if_req) begin
            if_win_s = 1'b1;
        end else if (mem_req) begin
            mem_win_s = 1'b1;
        end else if (if_req) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s  = 1'b0;
            mem_win_s = 1'b0;
        end
    end

    // A read granted on a final cycle keeps the FSM in RD_WAIT back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            rst_q_r <= 1'b1;
        end else begin
            rst_q_r <= 1'b0;
            if (rd_grant_s) begin
                state_r <= S_RD_WAIT;
            end else if (rd_final_s) begin
                state_r <= S_IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    mem_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk         (clk),
        .rst         (rst),
        .busy        (state_r == S_RD_WAIT),
        .start       (rd_grant_s),
        .start_owner (if_win_s ? OWN_IF : OWN_MEM),
        .final_cyc   (rd_final_s),
        .owner       (rd_owner_s)
    );

    // Memory bus and handshake outputs; everything rests at zero when unused.
    always_comb begin
        if_gnt            = if_win_s;
        mem_gnt           = mem_win_s;
        Memory_enable     = if_win_s | mem_win_s;
        Memory_addressbus = {ADDR_W{1'b0}};
        Memory_writemode  = 1'b0;
        Memory_wdata      = {DATA_W{1'b0}};
        if (mem_win_s) begin
            Memory_addressbus = mem_addr;
            Memory_writemode  = mem_we;
            Memory_wdata      = mem_we ? mem_wdata : {DATA_W{1'b0}};
        end else if (if_win_s) begin
            Memory_addressbus = if_addr;
        end else begin
            Memory_addressbus = {ADDR_W{1'b0}};
        end
        if_rvalid  = rvalid_s & (rd_owner_s == OWN_IF);
        mem_rvalid = rvalid_s & (rd_owner_s == OWN_MEM);
        if_rdata   = if_rvalid ? Memory_rdata : {DATA_W{1'b0}};
        mem_rdata  = mem_rvalid ? Memory_rdata : {DATA_W{1'b0}};
    end

endmodule
